rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (a bus, memory port or functional unit) among N requesters.
- Issues a registered one-hot grant to exactly one requester at a time.
- The owner holds the grant until it signals done, drops its request, or exhausts a hold budget.
- Sits between requester FSMs and the shared resource's mux select.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (1..255).
- IDW, 2, width of gnt_id; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- done  input  N  release strobe; bit i high = requester i is finished (only the owner's bit is examined).
- gnt  output  N  one-hot grant, registered; all zero when idle.
- gnt_id  output  IDW  index of the current owner; holds the last owner while idle.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold budget.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=N-1, cnt=0.
  - Requester 0 therefore has top priority on the first arbitration.
- Release of reset is synchronous to clk; the first arbitration occurs on the first rising edge with rst_n=1.
- All outputs are registered; no combinational path from req or done to any output.
- State IDLE:
  - If req==0: stay IDLE; gnt=0, busy=0.
  - Else the winner is the first set req bit scanning from (ptr+1) mod N upward with wrap-around.
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_id=winner, ptr=winner, cnt=1, busy=1.
  - Latency from req rising to gnt = 1 cycle.
- State GRANT (owner = gnt_id), evaluated each edge in priority order:
  1. done[owner]=1 or req[owner]=0: state=IDLE, gnt=0, busy=0, timeout=0.
  2. Else if cnt==MAX_HOLD: state=IDLE, gnt=0, busy=0, timeout=1 for exactly one cycle.
  3. Else cnt=cnt+1; gnt unchanged.
- Hold budget: the owner sees gnt high for at most MAX_HOLD cycles.
- Every release passes through at least one IDLE cycle with gnt=0, so there is a one-cycle bubble between owners.
- done and req of non-owners are ignored during GRANT; pending requests wait.
- Simultaneous done[owner] and cnt==MAX_HOLD: treated as a normal release, timeout stays 0.
- ptr advances only on a grant, never on release. A timed-out requester that keeps requesting goes behind all other active requesters.
- Single requester asserting continuously: it is re-granted after each one-cycle bubble.
- Wrap-around: with ptr=N-1 the scan starts at 0. With ptr=k and only req[k] set, k wins again.
- Reset asserted mid-grant: gnt drops to 0 immediately (asynchronously); no timeout pulse.
- cnt is wide enough for MAX_HOLD (8 bits) and never wraps.
- A req bit that drops in the same cycle it would win (IDLE) is simply not seen; no glitch grant.

Test Plan:
- Reset, then req=4'b0101 held with done pulsed one cycle after each grant -> gnt=0001 one cycle after req, released, bubble, then 0100, then 0001 (alternating); gnt_id 0,2,0.
- req=4'b1111, no done -> each owner holds exactly 8 cycles with timeout pulses; grant order 0,1,2,3,0; one zero-gnt cycle between owners.
- Only req[3] held, done never asserted -> gnt=1000 for 8 cycles, timeout=1 for one cycle, one idle cycle, gnt=1000 again; ptr stays at 3.
- Owner 1 asserts done on the same edge cnt==8 -> gnt drops, timeout stays 0.
- Owner 2 granted, rst_n driven low mid-cycle -> gnt=0, busy=0 with no clock edge; after release, req=0100 yields gnt=0100 again with priority restarted from 0.
- Owner 0 drops req after 3 cycles while req[1] is high -> gnt=0 next cycle, then gnt=0010, busy stays high except during the bubble cycle.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant to one of N requesters, held until
// done, request drop, or MAX_HOLD cycles, with a one-cycle idle bubble between owners.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         r_state, w_state_nx;
    logic [N-1:0]   r_gnt, w_gnt_nx;
    logic [IDW-1:0] r_id, w_id_nx;
    logic [IDW-1:0] r_ptr, w_ptr_nx;
    logic [7:0]     r_cnt, w_cnt_nx;
    logic           r_to, w_to_nx;

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [IDW-1:0] w_win;

    // Rotate so bit 0 of w_rot is requester (ptr+1) mod N; the doubled vector handles wrap.
    assign w_req2 = {req, req};
    assign w_rot  = N'(w_req2 >> (r_ptr + 1'b1));

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_win   = IDW'((32'(r_ptr) + 1 + j) % N);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_id_nx    = r_id;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_to_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt_nx = '0;
                if (w_found) begin
                    w_state_nx = S_GRANT;
                    w_gnt_nx   = N'(1) << w_win;
                    w_id_nx    = w_win;
                    w_ptr_nx   = w_win;
                    w_cnt_nx   = 8'd1;
                end
            end
            S_GRANT: begin
                // A normal release wins over the budget, so done on the last cycle is not a timeout.
                if (done[r_id] || !req[r_id]) begin
                    w_state_nx = S_IDLE;
                    w_gnt_nx   = '0;
                end else if (r_cnt == 8'(MAX_HOLD)) begin
                    w_state_nx = S_IDLE;
                    w_gnt_nx   = '0;
                    w_to_nx    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_ptr   <= IDW'(N - 1);
            r_cnt   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_id    <= w_id_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_to    <= w_to_nx;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_id;
    assign busy    = (r_state == S_GRANT);
    assign timeout = r_to;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: vector table, hand-written multi-cycle corners, and a
// randomized run compared against an owner/hold-count reference model.
module tb_rr_arbiter;

    localparam int NREQ = 4;
    localparam int MH   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int nerr = 0;
    int nchk = 0;

    // reference model state
    int m_owner, m_last, m_id, m_held;
    bit m_to;

    rr_arbiter #(.N(NREQ), .MAX_HOLD(MH), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
        nchk++;
        if ({gnt, gnt_id, busy, timeout} !== {eg, eid, eb, et}) begin
            nerr++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                     name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_last = NREQ - 1; m_id = 0; m_held = 0; m_to = 0;
    endtask

    // One clock edge of the arbitration rules, using owner index and hold count.
    task automatic m_edge(input logic [3:0] rq, input logic [3:0] dn);
        if (m_owner < 0) begin
            m_to = 0;
            for (int k = 1; k <= NREQ; k++)
                if (m_owner < 0 && rq[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
            if (m_owner >= 0) begin
                m_last = m_owner; m_id = m_owner; m_held = 1;
            end
        end else if (dn[m_owner] || !rq[m_owner]) begin
            m_owner = -1; m_to = 0;
        end else if (m_held == MH) begin
            m_owner = -1; m_to = 1;
        end else begin
            m_held++; m_to = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge(req, done);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; done = '0;
        #1;
        check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] eg;
        m_reset();

        tbl[0]  = '{1'b1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b0011, 4'b1101, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].req; done = tbl[i].done;
            step();
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].to);
        end

        // All four requesting, no done: each owner holds MH cycles, then a timeout bubble.
        do_reset();
        req = 4'b1111; done = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < MH; c++) begin
                step();
                eg = '0; eg[r % 4] = 1'b1;
                check($sformatf("all_hold_o%0d_c%0d", r % 4, c), eg, 2'(r % 4), 1'b1, 1'b0);
            end
            step();
            check($sformatf("all_bubble_%0d", r), 4'b0000, 2'(r % 4), 1'b0, 1'b1);
        end

        // Lone requester 3: times out, bubble, re-granted.
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < MH; c++) begin
            step();
            check("lone3_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        step();
        check("lone3_timeout", 4'b0000, 2'd3, 1'b0, 1'b1);
        step();
        check("lone3_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Owner 1 signals done exactly when the budget is reached: plain release.
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < MH; c++) begin
            step();
            check("done_at_max_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        done = 4'b0010;
        step();
        check("done_at_max_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
        done = '0;

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 4'b0100;
        step();
        check("mid_rst_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid_rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Randomized: sticky requests with occasional toggles and sparse done strobes.
        do_reset();
        req = 4'($urandom);
        for (int cyc = 0; cyc < 800; cyc++) begin
            req  = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            done = 4'($urandom) & 4'($urandom) & 4'($urandom);
            step();
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            check($sformatf("rand%0d", cyc), eg, 2'(m_id), (m_owner >= 0), m_to);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
